// File: rtl/index_decoder_pkg.sv
// Shared types for the index decoder.
//   state_t : occupancy states of the output skid buffer
//   entry_t : one buffered decode result {onehot, err}. The one-hot field
//             is sized for the largest supported NUM_OUTPUTS (64). Narrower
//             instances use only the low bits.
package index_decoder_pkg;

   localparam int ONEHOT_MAX = 64;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [ONEHOT_MAX-1:0] onehot;
      logic                  err;
   } entry_t;

   // Mask that keeps the low n bits of a one-hot field.
   function automatic logic [ONEHOT_MAX-1:0] low_mask(input int n);
      logic [ONEHOT_MAX-1:0] m;
      m = '0;
      for (int i = 0; i < ONEHOT_MAX; i++) begin
         if (i < n) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/index_decoder_skid_buffer.sv
// Two-entry skid buffer (main + skid register) with valid/ready handshakes.
// in_ready is a registered output and has no combinational dependency on
// out_ready. Strict FIFO order is kept and entries are never dropped or
// duplicated.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_data/valid/ready   upstream handshake
//   out_data/valid/ready  downstream handshake (out_data = main register)
//
// state | meaning
// EMPTY | no entries held
// ONE   | main register occupied
// FULL  | main and skid registers occupied, in_ready low
module skid_buffer
   import index_decoder_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   state_t            state;
   logic [DATA_W-1:0] skid_q;
   logic              in_xfer;
   logic              out_xfer;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         out_data  <= '0;
         skid_q    <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (in_xfer && !out_xfer) begin
                  // Consumer stalled: park the new entry behind main.
                  skid_q   <= in_data;
                  in_ready <= 1'b0;
                  state    <= FULL;
               end else if (in_xfer && out_xfer) begin
                  out_data <= in_data;
               end else if (out_xfer) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               if (out_xfer) begin
                  out_data <= skid_q;
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: rtl/index_decoder.sv
// Binary-to-one-hot index decoder with a one-cycle, fully pipelined
// valid/ready output stage (2-entry skid buffer).
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_index, in_valid, in_ready input handshake, index of IDX_W bits
//   out_onehot, out_err          decoded result
//   out_valid, out_ready         output handshake
// Build option: INDEX_DECODER_RANGE_CHECK_EN adds a per-entry out-of-range
// flag on out_err. Without it out_err is tied low. An out-of-range index
// gives an all-zero one-hot in both builds.
module index_decoder
   import index_decoder_pkg::*;
#(
   parameter  int NUM_OUTPUTS = 8,
   localparam int IDX_W       = $clog2(NUM_OUTPUTS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [IDX_W-1:0]       in_index,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [NUM_OUTPUTS-1:0] out_onehot,
   output logic                   out_err,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam logic [ONEHOT_MAX-1:0] OUT_MASK = low_mask(NUM_OUTPUTS);
   localparam logic [ONEHOT_MAX-1:0] ONE_BIT  = {{(ONEHOT_MAX-1){1'b0}}, 1'b1};

   entry_t dec_entry;
   entry_t buf_q;
   logic   unused_bits;

   // An out-of-range index lands on a bit above NUM_OUTPUTS-1, so the mask
   // alone zeroes it. No comparator is needed for that.
   always_comb begin
      dec_entry        = '0;
      dec_entry.onehot = (ONE_BIT << in_index) & OUT_MASK;
`ifdef INDEX_DECODER_RANGE_CHECK_EN
      dec_entry.err    = ({1'b0, in_index} >= (IDX_W+1)'(NUM_OUTPUTS));
`endif
   end

   skid_buffer #(
      .DATA_W ($bits(entry_t))
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (dec_entry),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (buf_q),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   assign out_onehot = buf_q.onehot[NUM_OUTPUTS-1:0];

`ifdef INDEX_DECODER_RANGE_CHECK_EN
   assign out_err = buf_q.err;
`else
   assign out_err = 1'b0;
`endif

   // Upper one-hot bits beyond NUM_OUTPUTS are always zero and are not read.
   assign unused_bits = ^buf_q;

endmodule

// File: doc/index_decoder.md
INDEX_DECODER -- requirements
Module: index_decoder

Interface
REQ-001 The block SHALL have parameter NUM_OUTPUTS, default 8, giving the one-hot output width; legal range 2..64.
REQ-002 The block SHALL have localparam IDX_W = $clog2(NUM_OUTPUTS), giving the index width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in_index, input, IDX_W bits: binary index to decode.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_index is valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_index this cycle.
REQ-008 The block SHALL have port out_onehot, output, NUM_OUTPUTS bits: decoded one-hot vector.
REQ-009 The block SHALL have port out_err, output, 1 bit: in_index was >= NUM_OUTPUTS.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_onehot/out_err are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the output this cycle.

Function
REQ-012 An input transfer SHALL occur on a cycle with in_valid && in_ready; an output transfer SHALL occur on a cycle with out_valid && out_ready.
REQ-013 Decode SHALL be out_onehot[i] = 1 iff i == in_index; exactly one bit set for an in-range index.
REQ-014 Out-of-range index (only possible when NUM_OUTPUTS is not a power of 2) SHALL yield out_onehot = '0.
REQ-015 Latency SHALL be 1 cycle: an index accepted at edge N SHALL appear on out_* after edge N with out_valid=1.
REQ-016 Buffering SHALL be a 2-entry skid buffer (main register + skid register) with sustained throughput of 1 transfer/cycle while out_ready=1.
REQ-017 in_ready SHALL be registered and equal NOT(skid register occupied); it SHALL have no combinational path from out_ready.
REQ-018 The states SHALL be EMPTY (no entries), ONE (main occupied), and FULL (main+skid occupied).
REQ-019 EMPTY SHALL transition to ONE on an input transfer.
REQ-020 ONE SHALL transition to FULL on an input transfer without an output transfer, to EMPTY on an output transfer without an input transfer, and remain in ONE on simultaneous input and output transfers (main reloaded).
REQ-021 FULL SHALL transition to ONE on an output transfer (skid moves to main); no input transfer is possible while FULL.
REQ-022 Ordering SHALL be strict FIFO; no entry SHALL be dropped or duplicated.
REQ-023 While out_valid=1 && out_ready=0, out_onehot/out_err SHALL be held stable.
REQ-024 in_index SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately (asynchronously) force state EMPTY, out_valid=0, out_onehot='0, out_err=0, and in_ready=1, including mid-transfer; buffered entries SHALL be discarded.
REQ-026 After reset release, the first input transfer SHALL be possible on the first clock edge.

Configuration
REQ-027 The macro INDEX_DECODER_RANGE_CHECK_EN SHALL control range checking.
REQ-028 With INDEX_DECODER_RANGE_CHECK_EN defined: the range comparison SHALL be stored per entry and out_err=1 SHALL accompany the out-of-range result with out_onehot='0.
REQ-029 Without INDEX_DECODER_RANGE_CHECK_EN: no comparator SHALL be present, out_err SHALL be tied 0, and out-of-range still SHALL yield out_onehot='0; the port list SHALL be unchanged.

Structure
REQ-030 Package index_decoder_pkg SHALL hold the state enum (EMPTY, ONE, FULL) and an entry struct typedef {onehot, err}.
REQ-031 The block SHALL have one sub-module, skid_buffer, parameterized by data width, instantiated with the entry struct; decode logic SHALL sit before it.

Verification
REQ-032 Reset sequence: rst_n low then high, idle inputs -> out_valid=0, in_ready=1, out_onehot=8'h00.
REQ-033 Single decode: NUM_OUTPUTS=8, send index 5 with out_ready=1 -> next cycle out_onehot=8'b0010_0000, out_valid=1, out_err=0.
REQ-034 Backpressure: out_ready=0, send 3,6 -> in_ready=0 after the second transfer, output holds 8'h08; raise out_ready -> 8'h08 then 8'h40, no loss.
REQ-035 Streaming: out_ready=1, indices 0..7 on consecutive cycles -> one-hot 01,02,..,80 on consecutive cycles, in_ready constantly 1.
REQ-036 Range check: NUM_OUTPUTS=6, macro defined, send index 7 -> out_onehot=6'b0, out_err=1; macro undefined -> out_err=0.
REQ-037 Mid-operation reset: FULL state, assert rst_n mid-cycle -> out_valid drops without a clock edge, in_ready=1, no stale output after release.
